// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined adder/subtractor.
// Chunk geometry and the legality check for WIDTH/STAGES pairs.
package adder_pkg;

  function automatic int chunk_w(input int width, input int stages);
    return (stages > 0) ? width / stages : width;
  endfunction

  // Width must split into STAGES equal, non-empty chunks.
  function automatic bit geom_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational W-bit ripple add of one carry-chain chunk.
// Produces the chunk sum and the carry into the next chunk.
module adder_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  logic [W:0] full;

  always_comb begin
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
  end

  assign s  = full[W-1:0];
  assign co = full[W];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor, one carry-chain chunk per stage.
// Valid/ready handshake with a global stall; flags from the last stage.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CHUNK = chunk_w(WIDTH, STAGES);

  if (!geom_ok(WIDTH, STAGES)) begin : g_bad_geom
    $error("pipelined_adder: WIDTH must be a multiple of STAGES");
  end

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  logic             vld_w [STAGES];
  logic             cy_w  [STAGES];
  logic [WIDTH-1:0] res_w [STAGES];
  logic [WIDTH-1:0] opa_w [STAGES];
  logic [WIDTH-1:0] opb_w [STAGES];

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign b_eff    = sub ? ~b : b;
  assign c0       = sub ? 1'b1 : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             in_vld;
    logic             in_cy;
    logic [WIDTH-1:0] in_res;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;

    if (k == 0) begin : g_head
      assign in_vld = in_valid;
      assign in_cy  = c0;
      assign in_res = '0;
      assign in_a   = a;
      assign in_b   = b_eff;
    end else begin : g_body
      assign in_vld = vld_w[k-1];
      assign in_cy  = cy_w[k-1];
      assign in_res = res_w[k-1];
      assign in_a   = opa_w[k-1];
      assign in_b   = opb_w[k-1];
    end

    logic [CHUNK-1:0] ch_s;
    logic             ch_co;

    adder_chunk #(
      .W(CHUNK)
    ) u_chunk (
      .a (in_a[k*CHUNK +: CHUNK]),
      .b (in_b[k*CHUNK +: CHUNK]),
      .ci(in_cy),
      .s (ch_s),
      .co(ch_co)
    );

    logic             vld_q, vld_d;
    logic             cy_q, cy_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] res_n;

    // Lower chunks ride along; this stage fills in chunk k.
    always_comb begin
      res_n = in_res;
      res_n[k*CHUNK +: CHUNK] = ch_s;
    end

    always_comb begin
      vld_d = vld_q;
      cy_d  = cy_q;
      res_d = res_q;
      if (advance) begin
        vld_d = in_vld;
        cy_d  = ch_co;
        res_d = res_n;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        res_q <= '0;
      end else begin
        vld_q <= vld_d;
        cy_q  <= cy_d;
        res_q <= res_d;
      end
    end

    assign vld_w[k] = vld_q;
    assign cy_w[k]  = cy_q;
    assign res_w[k] = res_q;

    if (k < STAGES - 1) begin : g_ops
      logic [WIDTH-1:0] opa_q, opa_d;
      logic [WIDTH-1:0] opb_q, opb_d;

      always_comb begin
        opa_d = opa_q;
        opb_d = opb_q;
        if (advance) begin
          opa_d = in_a;
          opb_d = in_b;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          opa_q <= '0;
          opb_q <= '0;
        end else begin
          opa_q <= opa_d;
          opb_q <= opb_d;
        end
      end

      assign opa_w[k] = opa_q;
      assign opb_w[k] = opb_q;
    end else begin : g_tail
      logic ovf_q, ovf_d;
      logic zero_q, zero_d;
      logic ovf_n;
      logic unused_ops;

      // Signed overflow: like-signed operands, result sign flipped.
      always_comb begin
        ovf_n = (in_a[WIDTH-1] == in_b[WIDTH-1]) &&
                (res_n[WIDTH-1] != in_a[WIDTH-1]);
      end

      always_comb begin
        ovf_d  = ovf_q;
        zero_d = zero_q;
        if (advance) begin
          ovf_d  = ovf_n;
          zero_d = (res_n == '0);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else begin
          ovf_q  <= ovf_d;
          zero_q <= zero_d;
        end
      end

      assign opa_w[k]   = in_a;
      assign opb_w[k]   = in_b;
      assign unused_ops = ^{opa_w[k], opb_w[k]};
      assign ovf        = ovf_q;
      assign zero       = zero_q;
    end
  end

  assign out_valid = vld_w[STAGES-1];
  assign sum       = res_w[STAGES-1];
  assign cout      = cy_w[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed flag cases, random stream with
// backpressure against a queue-based arithmetic model, bubbles, reset.
module tb_pipelined_adder;

  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  int n_vec;
  int n_err;

  pipelined_adder #(
    .WIDTH (WIDTH),
    .STAGES(STAGES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed result: {sum, cout, ovf, zero}
  function automatic logic [18:0] model(input logic [15:0] ma,
                                        input logic [15:0] mb,
                                        input logic mcin,
                                        input logic msub);
    int ua, ub, sa, sb, us, ss;
    logic [15:0] s;
    logic c, o, z;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (msub) begin
      us = ua - ub;
      ss = sa - sb;
      c  = (ua >= ub);
    end else begin
      us = ua + ub + int'(mcin);
      ss = sa + sb + int'(mcin);
      c  = (us > 65535);
    end
    s = us[15:0];
    o = (ss > 32767) || (ss < -32768);
    z = (s == 16'h0);
    return {s, c, o, z};
  endfunction

  task automatic test_reset_state();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({out_valid, sum, cout, ovf, zero, in_ready} !== {1'b0, 16'h0, 3'b000, 1'b1}) begin
      n_err++;
      $display("FAIL reset_state: got ov=%b sum=%h c=%b o=%b z=%b rdy=%b want 0 0000 0 0 0 1",
               out_valid, sum, cout, ovf, zero, in_ready);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [15:0] va [6] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005, 16'h0007, 16'h1234};
    logic [15:0] vb [6] = '{16'h0001, 16'h0001, 16'h8000, 16'h0007, 16'h0005, 16'h0FFF};
    logic        vc [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        vs [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [18:0] ve [6] = '{{16'h0000, 3'b101}, {16'h8000, 3'b010},
                            {16'h0000, 3'b111}, {16'hFFFE, 3'b000},
                            {16'h0002, 3'b100}, {16'h2234, 3'b000}};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = 1'b1;
      a = va[i]; b = vb[i]; cin = vc[i]; sub = vs[i];
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL directed_early[%0d]: out_valid=%b want 0", i, out_valid);
      end
      @(posedge clk);
      #1;
      n_vec++;
      if ({out_valid, sum, cout, ovf, zero} !== {1'b1, ve[i]}) begin
        n_err++;
        $display("FAIL directed[%0d]: got v=%b sum=%h c=%b o=%b z=%b want v=1 %h/%b",
                 i, out_valid, sum, cout, ovf, zero, ve[i][18:3], ve[i][2:0]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [18:0] q[$];
    logic [18:0] exp_r;
    logic [18:0] held;
    logic        prev_stall;
    int          sent;
    int          cyc;
    prev_stall = 1'b0;
    held = '0;
    sent = 0;
    cyc = 0;
    while ((sent < 20 || q.size() > 0) && cyc < 600) begin
      @(negedge clk);
      if (prev_stall) begin
        n_vec++;
        if ({out_valid, sum, cout, ovf, zero} !== {1'b1, held}) begin
          n_err++;
          $display("FAIL stall_hold: got v=%b %h/%b%b%b want v=1 %h/%b",
                   out_valid, sum, cout, ovf, zero, held[18:3], held[2:0]);
        end
      end
      out_ready = ($urandom_range(0, 2) != 0);
      in_valid = (sent < 20);
      a = 16'($urandom);
      b = 16'($urandom);
      cin = 1'($urandom);
      sub = 1'($urandom);
      #1;
      n_vec++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        n_err++;
        $display("FAIL in_ready: got %b want %b", in_ready, !(out_valid && !out_ready));
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL extra_beat: got sum=%h want no beat", sum);
        end else begin
          exp_r = q.pop_front();
          if ({sum, cout, ovf, zero} !== exp_r) begin
            n_err++;
            $display("FAIL stream: got %h/%b%b%b want %h/%b",
                     sum, cout, ovf, zero, exp_r[18:3], exp_r[2:0]);
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, cin, sub));
        sent++;
      end
      prev_stall = out_valid && !out_ready;
      held = {sum, cout, ovf, zero};
      cyc++;
    end
    n_vec++;
    if (q.size() != 0 || sent != 20) begin
      n_err++;
      $display("FAIL stream_drain: got pending=%0d sent=%0d want 0 and 20", q.size(), sent);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stream_idle: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_bubbles();
    logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic obs [12];
    out_ready = 1'b1;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      obs[t] = out_valid;
      in_valid = (t < 5) ? pat[t] : 1'b0;
      a = 16'($urandom);
      b = 16'($urandom);
    end
    in_valid = 1'b0;
    for (int t = 0; t < 8; t++) begin
      n_vec++;
      if (obs[t + STAGES] !== ((t < 5) ? pat[t] : 1'b0)) begin
        n_err++;
        $display("FAIL bubble[%0d]: out_valid=%b want %b",
                 t, obs[t + STAGES], (t < 5) ? pat[t] : 1'b0);
      end
    end
    n_vec++;
    if ({obs[0], obs[1], obs[2], obs[3]} !== 4'b0000) begin
      n_err++;
      $display("FAIL bubble_lead: got %b%b%b%b want 0000", obs[0], obs[1], obs[2], obs[3]);
    end
  endtask

  task automatic test_reset_midflight();
    logic seen;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = 16'h00F0 + 16'(i);
      b = 16'h0101;
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || sum !== 16'h0) begin
      n_err++;
      $display("FAIL reset_async: got v=%b sum=%h want 0 0000", out_valid, sum);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL reset_stale: got stale beat=%b want 0", seen);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset_state();
    test_directed();
    test_back_to_back();
    test_bubbles();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
